// File: rtl/pmem_read_arbiter.sv
// Round-robin arbiter that serialises two program-memory read requesters onto one read port.
// Optional GRANT watchdog enabled by defining PMEM_ARB_TIMEOUT_EN.
module pmem_read_arbiter #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              a_req_in,
    input  logic [ADDR_W-1:0] a_addr_in,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] a_data_out,
    output logic              a_err_out,
    input  logic              b_req_in,
    input  logic [ADDR_W-1:0] b_addr_in,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    output logic              b_err_out,
    input  logic              mem_ready_in,
    output logic              mem_read_request_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_valid_in,
    output logic              busy_out,
    output logic              owner_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              ptr, ptr_next;
    logic              winner_c;
    logic              timeout_c;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic              owner_next;
    logic              busy_next;
    logic              a_valid_next, b_valid_next;
    logic              a_err_next, b_err_next;
    logic [DATA_W-1:0] a_data_next, b_data_next;

`ifdef PMEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt, cnt_next;

    // The timeout fires in the TIMEOUT_CYCLES-th GRANT cycle.
    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_next = cnt;
        if (state == IDLE) begin
            cnt_next = '0;
        end else if (state == GRANT) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`else
    // Without the watchdog GRANT waits forever and the err outputs stay 0.
    logic unused_timeout;
    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        req_next     = mem_read_request_out;
        addr_next    = mem_addr_out;
        owner_next   = owner_out;
        a_valid_next = 1'b0;
        b_valid_next = 1'b0;
        a_err_next   = 1'b0;
        b_err_next   = 1'b0;
        a_data_next  = a_data_out;
        b_data_next  = b_data_out;
        // ptr names the port preferred when both request (the one not served last).
        winner_c     = (a_req_in && b_req_in) ? ptr : b_req_in;

        case (state)
            IDLE: begin
                if (mem_ready_in && (a_req_in || b_req_in)) begin
                    state_next = GRANT;
                    req_next   = 1'b1;
                    addr_next  = winner_c ? b_addr_in : a_addr_in;
                    owner_next = winner_c;
                    ptr_next   = ~winner_c;
                end
            end
            GRANT: begin
                if (mem_valid_in) begin
                    state_next = RESP;
                    req_next   = 1'b0;
                    if (owner_out) begin
                        b_valid_next = 1'b1;
                        b_data_next  = mem_data_in;
                    end else begin
                        a_valid_next = 1'b1;
                        a_data_next  = mem_data_in;
                    end
                end else if (timeout_c) begin
                    state_next = RESP;
                    req_next   = 1'b0;
                    if (owner_out) begin
                        b_valid_next = 1'b1;
                        b_err_next   = 1'b1;
                        b_data_next  = '0;
                    end else begin
                        a_valid_next = 1'b1;
                        a_err_next   = 1'b1;
                        a_data_next  = '0;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight read.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state                <= IDLE;
            ptr                  <= 1'b0;
            mem_read_request_out <= 1'b0;
            mem_addr_out         <= '0;
            owner_out            <= 1'b0;
            busy_out             <= 1'b0;
            a_valid_out          <= 1'b0;
            b_valid_out          <= 1'b0;
            a_err_out            <= 1'b0;
            b_err_out            <= 1'b0;
            a_data_out           <= '0;
            b_data_out           <= '0;
        end else begin
            state                <= state_next;
            ptr                  <= ptr_next;
            mem_read_request_out <= req_next;
            mem_addr_out         <= addr_next;
            owner_out            <= owner_next;
            busy_out             <= busy_next;
            a_valid_out          <= a_valid_next;
            b_valid_out          <= b_valid_next;
            a_err_out            <= a_err_next;
            b_err_out            <= b_err_next;
            a_data_out           <= a_data_next;
            b_data_out           <= b_data_next;
        end
    end

endmodule

// File: tb/tb_pmem_read_arbiter.sv
// Bench for pmem_read_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pmem_read_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
`ifdef PMEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO    = 8;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 255;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              a_req_in, b_req_in;
    logic [ADDR_W-1:0] a_addr_in, b_addr_in;
    logic              a_valid_out, b_valid_out;
    logic [DATA_W-1:0] a_data_out, b_data_out;
    logic              a_err_out, b_err_out;
    logic              mem_ready_in;
    logic              mem_read_request_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_valid_in;
    logic              busy_out;
    logic              owner_out;

    int checks = 0;
    int errors = 0;

    pmem_read_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .a_req_in            (a_req_in),
        .a_addr_in           (a_addr_in),
        .a_valid_out         (a_valid_out),
        .a_data_out          (a_data_out),
        .a_err_out           (a_err_out),
        .b_req_in            (b_req_in),
        .b_addr_in           (b_addr_in),
        .b_valid_out         (b_valid_out),
        .b_data_out          (b_data_out),
        .b_err_out           (b_err_out),
        .mem_ready_in        (mem_ready_in),
        .mem_read_request_out(mem_read_request_out),
        .mem_addr_out        (mem_addr_out),
        .mem_data_in         (mem_data_in),
        .mem_valid_in        (mem_valid_in),
        .busy_out            (busy_out),
        .owner_out           (owner_out)
    );

    always #5 clk_in = ~clk_in;

    // Transaction-level model: one read outstanding, one response cycle, then free again.
    bit                m_out, m_resp, m_prefer;
    int unsigned       m_wait;
    logic              e_req, e_owner, e_busy, e_av, e_bv, e_ae, e_be;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_ad, e_bd;

    task automatic finish_read(input logic [DATA_W-1:0] d, input bit err);
        m_out  = 1'b0;
        m_resp = 1'b1;
        if (e_owner) begin
            e_bv = 1'b1; e_be = err; e_bd = d;
        end else begin
            e_av = 1'b1; e_ae = err; e_ad = d;
        end
    endtask

    task automatic model_edge();
        if (!rst_in) begin
            m_out = 0; m_resp = 0; m_prefer = 0; m_wait = 0;
            e_req = 0; e_owner = 0; e_busy = 0; e_addr = '0;
            e_av = 0; e_bv = 0; e_ae = 0; e_be = 0; e_ad = '0; e_bd = '0;
            return;
        end
        e_av = 0; e_bv = 0; e_ae = 0; e_be = 0;
        if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_out) begin
            m_wait++;
            if (mem_valid_in) finish_read(mem_data_in, 1'b0);
            else if (TMO_EN && m_wait >= TMO) finish_read('0, 1'b1);
        end else if (mem_ready_in && (a_req_in || b_req_in)) begin
            bit w = (a_req_in && b_req_in) ? m_prefer : b_req_in;
            m_prefer = !w;
            m_out    = 1'b1;
            m_wait   = 0;
            e_owner  = w;
            e_addr   = w ? b_addr_in : a_addr_in;
        end
        e_req  = m_out;
        e_busy = m_out || m_resp;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_req", 64'(mem_read_request_out), 64'(e_req));
        chk("mem_addr", 64'(mem_addr_out), 64'(e_addr));
        chk("owner", 64'(owner_out), 64'(e_owner));
        chk("busy", 64'(busy_out), 64'(e_busy));
        chk("a_valid", 64'(a_valid_out), 64'(e_av));
        chk("b_valid", 64'(b_valid_out), 64'(e_bv));
        chk("a_err", 64'(a_err_out), 64'(e_ae));
        chk("b_err", 64'(b_err_out), 64'(e_be));
        chk("a_data", 64'(a_data_out), 64'(e_ad));
        chk("b_data", 64'(b_data_out), 64'(e_bd));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic do_reset();
        rst_in = 1'b0; a_req_in = 1'b0; b_req_in = 1'b0;
        mem_valid_in = 1'b0; mem_data_in = '0; mem_ready_in = 1'b1;
        step();
        step();
        rst_in = 1'b1;
    endtask

    // Waits (bounded) for the read request, then answers after `delay` further cycles.
    task automatic serve(input logic [DATA_W-1:0] data, input int delay);
        int n = 0;
        while (!mem_read_request_out && n < 50) begin
            step();
            n++;
        end
        if (!mem_read_request_out) begin
            checks++;
            errors++;
            $display("FAIL serve_wait: mem_read_request_out stayed 0 for %0d cycles", n);
            return;
        end
        repeat (delay) step();
        mem_valid_in = 1'b1;
        mem_data_in  = data;
        step();
        mem_valid_in = 1'b0;
        mem_data_in  = '0;
    endtask

    initial begin
        rst_in = 1'b0; a_req_in = 1'b0; b_req_in = 1'b0;
        a_addr_in = '0; b_addr_in = '0;
        mem_ready_in = 1'b0; mem_valid_in = 1'b0; mem_data_in = '0;

        // Reset state.
        do_reset();
        chk("rst_mem_req", 64'(mem_read_request_out), 64'd0);
        chk("rst_a_data", 64'(a_data_out), 64'd0);

        // Single A read.
        a_req_in = 1'b1; a_addr_in = 16'h0010;
        step();
        chk("t1_req", 64'(mem_read_request_out), 64'd1);
        chk("t1_addr", 64'(mem_addr_out), 64'h0010);
        serve(32'hDEADBEEF, 2);
        chk("t1_a_valid", 64'(a_valid_out), 64'd1);
        chk("t1_a_data", 64'(a_data_out), 64'hDEADBEEF);
        chk("t1_b_valid", 64'(b_valid_out), 64'd0);
        a_req_in = 1'b0;
        step();
        chk("t1_pulse_end", 64'(a_valid_out), 64'd0);

        // Stray memory strobe while idle.
        step();
        mem_valid_in = 1'b1; mem_data_in = 32'h12345678;
        step();
        mem_valid_in = 1'b0; mem_data_in = '0;
        step();
        chk("t6_a_valid", 64'(a_valid_out), 64'd0);
        chk("t6_b_valid", 64'(b_valid_out), 64'd0);
        chk("t6_a_data", 64'(a_data_out), 64'hDEADBEEF);
        chk("t6_b_data", 64'(b_data_out), 64'd0);

        // Both ports requesting continuously: strict alternation starting with A.
        do_reset();
        a_req_in = 1'b1; a_addr_in = 16'h0001;
        b_req_in = 1'b1; b_addr_in = 16'h0002;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            step();
            chk("t2_req", 64'(mem_read_request_out), 64'd1);
            chk("t2_addr", 64'(mem_addr_out), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("t2_owner", 64'(owner_out), 64'(i % 2));
            serve(32'hA000_0000 + 32'(i), 0);
            chk("t2_valid", (i % 2 == 0) ? 64'(a_valid_out) : 64'(b_valid_out), 64'd1);
            chk("t2_data", (i % 2 == 0) ? 64'(a_data_out) : 64'(b_data_out), 64'hA000_0000 + 64'(i));
        end

        // Memory not ready holds off the grant.
        do_reset();
        mem_ready_in = 1'b0;
        a_req_in = 1'b1; a_addr_in = 16'h0030; b_req_in = 1'b0;
        repeat (20) begin
            step();
            chk("t3_no_req", 64'(mem_read_request_out), 64'd0);
        end
        mem_ready_in = 1'b1;
        step();
        chk("t3_req", 64'(mem_read_request_out), 64'd1);
        serve(32'h0BAD_F00D, 1);
        a_req_in = 1'b0;
        step();

        // Reset in the middle of a B grant.
        do_reset();
        b_req_in = 1'b1; b_addr_in = 16'h0002;
        step();
        chk("t4_owner_b", 64'(owner_out), 64'd1);
        a_req_in = 1'b1; a_addr_in = 16'h0001;
        step();
        rst_in = 1'b0;
        step();
        chk("t4_req", 64'(mem_read_request_out), 64'd0);
        chk("t4_busy", 64'(busy_out), 64'd0);
        chk("t4_owner", 64'(owner_out), 64'd0);
        chk("t4_b_valid", 64'(b_valid_out), 64'd0);
        rst_in = 1'b1;
        step();
        chk("t4_first_a", 64'(owner_out), 64'd0);
        chk("t4_addr_a", 64'(mem_addr_out), 64'h1);
        serve(32'h1111_2222, 0);
        chk("t4_a_valid", 64'(a_valid_out), 64'd1);
        a_req_in = 1'b0;
        serve(32'h3333_4444, 0);
        chk("t4_b_valid2", 64'(b_valid_out), 64'd1);
        b_req_in = 1'b0;
        step();

`ifdef PMEM_ARB_TIMEOUT_EN
        // Memory never answers: forced error response after the timeout.
        begin
            int n = 0;
            do_reset();
            a_req_in = 1'b1; a_addr_in = 16'h0055;
            serve(32'hCAFEF00D, 0);
            step();
            step();
            while (mem_read_request_out && n < 20) begin
                n++;
                step();
            end
            chk("t5_grant_cycles", 64'(n), 64'd8);
            chk("t5_a_valid", 64'(a_valid_out), 64'd1);
            chk("t5_a_err", 64'(a_err_out), 64'd1);
            chk("t5_a_data", 64'(a_data_out), 64'd0);
            a_req_in = 1'b0;
            step();
        end
`endif

        // Randomized traffic, memory latency, readiness and occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_in       = ($urandom_range(0, 199) != 0);
            mem_ready_in = ($urandom_range(0, 5) != 0);
            if (mem_read_request_out) begin
                mem_valid_in = ($urandom_range(0, 2) == 0);
            end else begin
                mem_valid_in = ($urandom_range(0, 9) == 0);
            end
            mem_data_in = 32'($urandom);
            if (a_req_in && a_valid_out) begin
                if ($urandom_range(0, 1) == 0) a_req_in = 1'b0;
                else a_addr_in = 16'($urandom);
            end else if (!a_req_in && $urandom_range(0, 2) == 0) begin
                a_req_in = 1'b1; a_addr_in = 16'($urandom);
            end
            if (b_req_in && b_valid_out) begin
                if ($urandom_range(0, 1) == 0) b_req_in = 1'b0;
                else b_addr_in = 16'($urandom);
            end else if (!b_req_in && $urandom_range(0, 2) == 0) begin
                b_req_in = 1'b1; b_addr_in = 16'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
